// File: rtl/alu_pkg.sv
// Shared opcode constants and arbiter state encoding for the ALU subsystem.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_LDI = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_XOR = 4'd9;
  localparam logic [3:0] OP_NOT = 4'd10;
  localparam logic [3:0] OP_SHL = 4'd11;
  localparam logic [3:0] OP_SHR = 4'd12;
  localparam logic [3:0] OP_JMP = 4'd13;
  localparam logic [3:0] OP_BRZ = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit-class ALU. Control-flow opcodes (JMP/BRZ/HLT) and NOP return zero;
// the caller is responsible for any branch or halt semantics.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       ra_i,
  input  logic [3:0]       rb_i,
  output logic [WIDTH-1:0] out_o,
  output logic             cout_o,
  output logic             of_o
);

  logic [WIDTH-1:0]   imm_ext;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     adi_sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  assign imm_ext = WIDTH'({ra_i, rb_i});
  assign sum     = {1'b0, a_i} + {1'b0, b_i};
  assign adi_sum = {1'b0, a_i} + {1'b0, imm_ext};
  // Carry out of a + ~b + 1: set means "no borrow"
  assign diff    = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign prod    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Opcode decode and flag generation
  always_comb begin
    out_o  = '0;
    cout_o = 1'b0;
    of_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        out_o  = sum[WIDTH-1:0];
        cout_o = sum[WIDTH];
        of_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_LDI: out_o = imm_ext;
      OP_SUB: begin
        out_o  = diff[WIDTH-1:0];
        cout_o = diff[WIDTH];
        of_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_ADI: begin
        out_o  = adi_sum[WIDTH-1:0];
        cout_o = adi_sum[WIDTH];
        of_o   = (a_i[WIDTH-1] == imm_ext[WIDTH-1]) &&
                 (adi_sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_MUL: begin
        out_o  = prod[WIDTH-1:0];
        cout_o = |prod[2*WIDTH-1:WIDTH];
      end
      // Zero divisor yields all ones here to stay X-free; the arbiter flags the error
      OP_DIV: out_o = (b_i == '0) ? '1 : (a_i / b_i);
      OP_AND: out_o = a_i & b_i;
      OP_OR:  out_o = a_i | b_i;
      OP_XOR: out_o = a_i ^ b_i;
      OP_NOT: out_o = ~a_i;
      OP_SHL: begin
        out_o  = a_i << 1;
        cout_o = a_i[WIDTH-1];
      end
      OP_SHR: begin
        out_o  = a_i >> 1;
        cout_o = a_i[0];
      end
      default: out_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone valid wins, on contention the side that
// did not win last time is granted.
module rr_pick2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the valid pattern and previous winner
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters. Each accepted operation is
// registered onto the ALU inputs, evaluated for one cycle, captured, and held until
// its owner consumes it. Divide-by-zero is intercepted at capture time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [3:0]       req0_op,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [7:0]       req0_imm,
  input  logic [7:0]       req1_imm,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_of,
  output logic             rsp_err,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ra,
  output logic [3:0]       alu_rb,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_of,
  output logic             busy
);

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ra_q, alu_ra_d;
  logic [3:0]       alu_rb_q, alu_rb_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_of_q, rsp_of_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       grant;
  logic             div_zero;
  logic             rsp_ack;

  rr_pick2 u_pick (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign div_zero = (alu_op_q == OP_DIV) && (alu_b_q == '0);
  assign rsp_ack  = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state, operand latching, result capture and handshake outputs
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ra_d     = alu_ra_q;
    alu_rb_d     = alu_rb_q;
    rsp_data_d   = rsp_data_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_of_d     = rsp_of_q;
    rsp_err_d    = rsp_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;

    unique case (state_q)
      IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        // A grant implies the matching valid, so grant alone marks the handshake
        if (grant[1]) begin
          state_d  = ISSUE;
          owner_d  = 1'b1;
          alu_op_d = req1_op;
          alu_a_d  = req1_a;
          alu_b_d  = req1_b;
          alu_ra_d = req1_imm[7:4];
          alu_rb_d = req1_imm[3:0];
        end else if (grant[0]) begin
          state_d  = ISSUE;
          owner_d  = 1'b0;
          alu_op_d = req0_op;
          alu_a_d  = req0_a;
          alu_b_d  = req0_b;
          alu_ra_d = req0_imm[7:4];
          alu_rb_d = req0_imm[3:0];
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (div_zero) begin
          rsp_data_d = '1;
          rsp_cout_d = 1'b0;
          rsp_of_d   = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_out;
          rsp_cout_d = alu_cout;
          rsp_of_d   = alu_of;
          rsp_err_d  = 1'b0;
        end
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (rsp_ack) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ra_q     <= '0;
      alu_rb_q     <= '0;
      rsp_data_q   <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_of_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ra_q     <= alu_ra_d;
      alu_rb_q     <= alu_rb_d;
      rsp_data_q   <= rsp_data_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_of_q     <= rsp_of_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_ra   = alu_ra_q;
  assign alu_rb   = alu_rb_q;
  assign rsp_data = rsp_data_q;
  assign rsp_cout = rsp_cout_q;
  assign rsp_of   = rsp_of_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter driving a real alu. Inputs change and outputs are
// sampled 1-2 time units after the rising edge.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [7:0]       req0_imm, req1_imm;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout, rsp_of, rsp_err;
  logic [3:0]       alu_op, alu_ra, alu_rb;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_cout, alu_of, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req1_a     (req1_a),
    .req0_b     (req0_b),
    .req1_b     (req1_b),
    .req0_imm   (req0_imm),
    .req1_imm   (req1_imm),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_ready (rsp1_ready),
    .rsp_data   (rsp_data),
    .rsp_cout   (rsp_cout),
    .rsp_of     (rsp_of),
    .rsp_err    (rsp_err),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ra     (alu_ra),
    .alu_rb     (alu_rb),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_of     (alu_of),
    .busy       (busy)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .op_i   (alu_op),
    .a_i    (alu_a),
    .b_i    (alu_b),
    .ra_i   (alu_ra),
    .rb_i   (alu_rb),
    .out_o  (alu_out),
    .cout_o (alu_cout),
    .of_o   (alu_of)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0; req0_a = '0; req1_a = '0;
    req0_b = '0; req1_b = '0; req0_imm = '0; req1_imm = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    chk("rst_rsp", {rsp_data, rsp_cout, rsp_of, rsp_err}, 0);
    chk("rst_alu", {alu_op, alu_a, alu_b, alu_ra, alu_rb}, 0);

    // Single ADD: 100 + 27 = 127
    req0_op = 4'd1; req0_a = 8'd100; req0_b = 8'd27; req0_valid = 1'b1;
    #1;
    chk("add_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    chk("add_issue_busy", busy, 1);
    chk("add_issue_alu", {alu_op, alu_a, alu_b}, {4'd1, 8'd100, 8'd27});
    chk("add_issue_norsp", rsp0_valid, 0);
    tick();
    chk("add_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    chk("add_rsp", {rsp_data, rsp_cout, rsp_of, rsp_err}, {8'd127, 3'b000});
    tick();
    chk("add_done", {busy, rsp0_valid}, 0);

    // Contention from reset: 0,1,0,1 with both held valid
    do_reset();
    req0_op = 4'd3; req0_a = 8'd5;   req0_b = 8'd7;
    req1_op = 4'd1; req1_a = 8'd200; req1_b = 8'd100;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        chk("cont_rdy_w0", {req1_ready, req0_ready}, 2'b01);
        tick(); tick();
        chk("cont_rsp_w0", {rsp1_valid, rsp0_valid}, 2'b01);
        chk("cont_data_w0", {rsp_data, rsp_cout, rsp_err}, {8'hFE, 2'b00});
      end else begin
        chk("cont_rdy_w1", {req1_ready, req0_ready}, 2'b10);
        tick(); tick();
        chk("cont_rsp_w1", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("cont_data_w1", {rsp_data, rsp_cout, rsp_err}, {8'd44, 2'b10});
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Divide by zero on requester 1, then a legal divide
    req1_op = 4'd6; req1_a = 8'd9; req1_b = 8'd0; req1_valid = 1'b1;
    #1;
    chk("dz_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("dz_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("dz_rsp", {rsp_data, rsp_cout, rsp_of, rsp_err}, {8'hFF, 3'b001});
    tick();
    req1_b = 8'd2; req1_valid = 1'b1;
    #1;
    chk("div_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("div_rsp", {rsp1_valid, rsp_data, rsp_err}, {1'b1, 8'd4, 1'b0});
    tick();

    // Response backpressure: req1 waits while rsp0 is stalled
    req0_op = 4'd1; req0_a = 8'd1; req0_b = 8'd2; req0_valid = 1'b1;
    req1_op = 4'd9; req1_a = 8'hF0; req1_b = 8'h0F; req1_valid = 1'b1;
    rsp0_ready = 1'b0;
    #1;
    chk("bp_rdy", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 1'b0;
    chk("bp_issue_rdy1", req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {busy, rsp0_valid, rsp_data, req1_ready}, {2'b11, 8'd3, 1'b0});
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_release_rdy1", {rsp0_valid, req1_ready}, 2'b10);
    tick();
    chk("bp_req1_accept", {busy, req1_ready}, 2'b01);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("bp_rsp1", {rsp1_valid, rsp_data}, {1'b1, 8'hFF});
    tick();

    // LDI immediate nibbles
    req0_op = 4'd2; req0_a = '0; req0_b = '0; req0_imm = 8'h5A; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("ldi_alu", {alu_op, alu_ra, alu_rb}, {4'd2, 4'h5, 4'hA});
    tick();
    chk("ldi_rsp", {rsp0_valid, rsp_data}, {1'b1, 8'h5A});
    tick();

    // Reset during ISSUE drops the operation
    req1_op = 4'd1; req1_a = 8'd3; req1_b = 8'd4; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    chk("rmid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rmid_outs", {busy, rsp1_valid, rsp0_valid, alu_op, alu_a, rsp_data},
        {3'b000, 4'd0, 8'd0, 8'd0});
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rmid_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
    req1_valid = 1'b1;
    #1;
    chk("rmid_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("rmid_rsp", {rsp1_valid, rsp_data}, {1'b1, 8'd7});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit combinational `alu` between two requesters, such as the MCU core and a debug/host port, using round-robin arbitration and valid/ready handshakes. It sits between the requesters and the ALU and owns the ALU input operands. Each accepted operation is registered, executed for one cycle, captured, and returned to its owner. The block also guards divide-by-zero, which the ALU does not handle.

## Interface
Parameters:
- `WIDTH`, default 8: data width of operands and result.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset_n`  in  1  reset, asynchronous and active-low
- `req0_valid`, `req1_valid`  in  1  requester has an operation pending
- `req0_ready`, `req1_ready`  out  1  arbiter accepts this requester's operation this cycle
- `req0_op`, `req1_op`  in  4  ALU opcode
- `req0_a`, `req1_a`, `req0_b`, `req1_b`  in  WIDTH  operands
- `req0_imm`, `req1_imm`  in  8  immediate; high nibble drives `alu_ra`, low nibble drives `alu_rb`
- `rsp0_valid`, `rsp1_valid`  out  1  result available for this requester
- `rsp0_ready`, `rsp1_ready`  in  1  requester consumes the result
- `rsp_data`  out  WIDTH  captured result, shared by both responders
- `rsp_cout`, `rsp_of`, `rsp_err`  out  1  captured carry, captured overflow, divide-by-zero flag
- `alu_op`  out  4  registered opcode driven to the ALU
- `alu_a`, `alu_b`  out  WIDTH  registered operands driven to the ALU
- `alu_ra`, `alu_rb`  out  4  registered immediate nibbles driven to the ALU
- `alu_out`  in  WIDTH  ALU result
- `alu_cout`, `alu_of`  in  1  ALU flags
- `busy`  out  1  asserted whenever the FSM is not in IDLE

## Operation
FSM states are IDLE, ISSUE and RESP; the reset state is IDLE.

- **IDLE**
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the requester that is not `last_grant`.
  - `reqN_ready` equals grant, and is driven combinationally in IDLE only.
  - On handshake (`valid & ready`), the operation's op, a, b and imm are latched into the `alu_*` registers, `owner` is set to the granted requester, and the FSM goes to ISSUE.
- **ISSUE**
  - The ALU evaluates the registered operands.
  - At the clock edge, `alu_out`, `alu_cout` and `alu_of` are captured into `rsp_data`, `rsp_cout` and `rsp_of`, with `rsp_err`=0, and the FSM goes to RESP.
  - Divide-by-zero case: if `alu_op`==6 (DIV) and `alu_b`==0, the block instead captures `rsp_data`=all ones, `rsp_cout`=0, `rsp_of`=0, `rsp_err`=1.
- **RESP**
  - `rsp<owner>_valid`=1; the other `rsp_valid` stays 0.
  - On `rsp<owner>_ready`, `last_grant` is set to `owner` and the FSM goes to IDLE.
  - The result is held stable until it is consumed.
- **Opcodes**: all 16 opcodes pass through unmodified. Opcodes 0, 13, 14 and 15 return whatever the ALU produces (0). The arbiter does not interpret branch or halt semantics.
- **Valid rule**: a requester must hold valid, op and operands stable until ready. Deasserting valid before ready simply withdraws the request.
- **Reset values**: all `ready`/`valid` outputs 0, `rsp_*`=0, `alu_*`=0, `busy`=0, `last_grant`=1 (so requester 0 wins the first contention), `owner`=0.
- **Reset mid-operation**: the in-flight operation is dropped and no response is issued. After `reset_n` rises, arbitration restarts from the reset values.
- **Width rules**: no width conversion inside the block; the ALU is instantiated with a matching `WIDTH`.

## Timing
- Accept at edge t:
  - `alu_*` are valid after t.
  - The result is captured at t+1.
  - `rsp_valid` is high after t+1.
- With `rsp_ready` held high, the response handshake occurs at edge t+2, and the earliest next accept is edge t+3. Throughput is one operation per 3 cycles.
- `req_ready` is never asserted outside IDLE. A request arriving during ISSUE/RESP waits.
- A new request and a response consumption in the same cycle: consumption moves the FSM to IDLE, and the new request is accepted on the following edge using the updated `last_grant`.
- The ALU path (`alu_*` regs → ALU → capture regs) must close in one `clk` period.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams: `OP_NOP`=0, `OP_ADD`=1, `OP_LDI`=2, `OP_SUB`=3, `OP_ADI`=4, `OP_MUL`=5, `OP_DIV`=6, … `OP_HLT`=15
  - typedef `arb_state_t` (IDLE, ISSUE, RESP)
- Sub-module `rr_pick2`: combinational two-way round-robin selector. Inputs are the two valids and `last_grant`; outputs are the one-hot grant. Everything else lives in `alu_arbiter`.
- The bench instantiates `alu_arbiter` with a real `alu`.

## Test plan
- **Single ADD**: `req0` op=1, a=8'd100, b=8'd27; `rsp0_ready`=1 → `req0_ready` at t, `rsp0_valid` after t+1, `rsp_data`=127, `rsp_cout`=0, `rsp_of`=0.
- **Contention from reset**: both valid (`req0` op=3, a=5, b=7; `req1` op=1, a=200, b=100).
  - `req0` wins first: `rsp_data`=8'hFE, `rsp_cout`=0.
  - `req1` wins second: `rsp_data`=8'd44, `rsp_cout`=1.
  - With both held valid continuously, grants alternate 0,1,0,1.
- **Divide-by-zero**: `req1` op=6, a=9, b=0 → `rsp1_valid`, `rsp_data`=8'hFF, `rsp_err`=1. Then op=6, a=9, b=2 → `rsp_data`=4, `rsp_err`=0.
- **Response backpressure**: `rsp0_ready`=0 for 5 cycles → `rsp0_valid`, `rsp_data` and `busy` hold, and `req1` (valid throughout) sees no ready. After ready rises, `req1` is accepted one cycle later.
- **LDI immediate**: op=2, imm=8'h5A → `alu_ra`=5, `alu_rb`=A, `rsp_data`=8'h5A.
- **Reset mid-op**: `reset_n` low during ISSUE → all outputs return to reset values, and no `rsp_valid` follows. The first request after release is accepted.
